mpsoc_msi_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one downstream master port, typically the slave port of the bus-width upsizer, between `NUM_MASTERS` upstream Wishbone masters. A grant is held for a whole `cyc` assertion, so classic and burst (`cti`/`bte`) cycles pass through unbroken. Between grants the arbiter forces one idle cycle so downstream sequencing logic sees `cyc` drop. An optional watchdog aborts a stalled cycle with `err` so one master cannot lock the bus.

---
 rtl/mpsoc_msi_arb_pkg.sv | 39 +++
 rtl/mpsoc_msi_wb_arbiter_if.sv | 64 ++++++
 rtl/mpsoc_msi_arb_rr.sv | 37 +++
 rtl/mpsoc_msi_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_mpsoc_msi_wb_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpsoc_msi_arb_pkg.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_arb_pkg
// Shared types and helpers for the round-robin Wishbone arbiter.
//   arb_state_e : arbiter FSM states
//   rr_pick     : first requester at or above ptr (with wrap), -1 if none
// ---------------------------------------------------------------------------
package mpsoc_msi_arb_pkg;

  // Upper bound on the port count the search helper can handle.
  localparam int MAX_MASTERS = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_ABORT   = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_e;

  // Search upward from ptr, wrapping at n; returns the winning index or -1.
  function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                 input int ptr,
                                 input int n);
    int                     winner;
    int                     idx;
    logic [MAX_MASTERS-1:0] shifted;
    winner = -1;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (k < n && winner < 0) begin
        idx     = (ptr + k) % n;
        shifted = req >> idx;
        if (shifted[0]) begin
          winner = idx;
        end
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/mpsoc_msi_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_wb_arbiter_if
// Bundles the upstream (wbs_*) ports, the downstream (wbm_*) port and the
// arbiter status outputs.
//   modport slave  : arbiter view (consumes requests, produces responses)
//   modport master : environment view (upstream masters + downstream slave)
// ---------------------------------------------------------------------------
interface mpsoc_msi_wb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DW          = 32,
  parameter int AW          = 32
);
  // Upstream side, one lane per master
  logic [NUM_MASTERS-1:0][AW-1:0]   wbs_adr_i;
  logic [NUM_MASTERS-1:0][DW-1:0]   wbs_dat_i;
  logic [NUM_MASTERS-1:0][DW/8-1:0] wbs_sel_i;
  logic [NUM_MASTERS-1:0]           wbs_we_i;
  logic [NUM_MASTERS-1:0]           wbs_cyc_i;
  logic [NUM_MASTERS-1:0]           wbs_stb_i;
  logic [NUM_MASTERS-1:0][2:0]      wbs_cti_i;
  logic [NUM_MASTERS-1:0][1:0]      wbs_bte_i;
  logic [DW-1:0]                    wbs_dat_o;
  logic [NUM_MASTERS-1:0]           wbs_ack_o;
  logic [NUM_MASTERS-1:0]           wbs_err_o;
  logic [NUM_MASTERS-1:0]           wbs_rty_o;

  // Downstream side
  logic [AW-1:0]                    wbm_adr_o;
  logic [DW-1:0]                    wbm_dat_o;
  logic [DW/8-1:0]                  wbm_sel_o;
  logic                             wbm_we_o;
  logic                             wbm_cyc_o;
  logic                             wbm_stb_o;
  logic [2:0]                       wbm_cti_o;
  logic [1:0]                       wbm_bte_o;
  logic [DW-1:0]                    wbm_dat_i;
  logic                             wbm_ack_i;
  logic                             wbm_err_i;
  logic                             wbm_rty_i;

  // Status
  logic [NUM_MASTERS-1:0]           grant_o;
  logic                             timeout_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
           wbs_cti_i, wbs_bte_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output grant_o, timeout_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
           wbs_cti_i, wbs_bte_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/mpsoc_msi_arb_rr.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_arb_rr
// Combinational round-robin grant generator.
//   req_i      : request vector
//   ptr_i      : index with highest priority this round
//   grant_o    : one-hot winner (zero when no request)
//   next_ptr_o : winner+1 mod NUM_MASTERS (ptr_i when no request)
//   valid_o    : at least one request present
// ---------------------------------------------------------------------------
module mpsoc_msi_arb_rr
  import mpsoc_msi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [PW-1:0]          ptr_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [PW-1:0]          next_ptr_o,
  output logic                   valid_o
);

  int winner;

  always_comb begin
    winner     = rr_pick(MAX_MASTERS'(req_i), int'(ptr_i), NUM_MASTERS);
    grant_o    = '0;
    next_ptr_o = ptr_i;
    valid_o    = 1'b0;
    if (winner >= 0) begin
      valid_o    = 1'b1;
      grant_o    = NUM_MASTERS'(1) << winner;
      next_ptr_o = PW'((winner + 1) % NUM_MASTERS);
    end
  end

endmodule

// File: rtl/mpsoc_msi_wb_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_wb_arbiter
// Round-robin Wishbone arbiter: NUM_MASTERS upstream ports share one
// downstream port. A grant lasts a whole cyc, a dead cycle separates owners,
// and an optional watchdog (TIMEOUT>0) aborts an unanswered strobe with err.
//   wb_clk_i  : clock, rising edge
//   wb_rst_ni : synchronous active-low reset
//   bus       : upstream/downstream Wishbone signals, grant_o, timeout_o
// ---------------------------------------------------------------------------
module mpsoc_msi_wb_arbiter
  import mpsoc_msi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  mpsoc_msi_wb_arbiter_if.slave bus
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] rr_grant;
  logic [PW-1:0]          rr_next;
  logic                   rr_valid;
  logic [PW-1:0]          gidx;
  logic                   fwd;
  logic                   resp;
  logic                   wd_fire;

  mpsoc_msi_arb_rr #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_rr (
    .req_i      (bus.wbs_cyc_i),
    .ptr_i      (ptr_q),
    .grant_o    (rr_grant),
    .next_ptr_o (rr_next),
    .valid_o    (rr_valid)
  );

  // Encode the registered one-hot grant for the muxes.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign fwd  = (state_q == S_GRANT);
  assign resp = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
  // Fires in the TIMEOUT-th consecutive unanswered strobe cycle.
  assign wd_fire = (TIMEOUT > 0) && fwd && bus.wbs_cyc_i[gidx] &&
                   bus.wbs_stb_i[gidx] && !resp && (wd_cnt_q == WD_LAST);

  // Request path is purely combinational while granted so slave latency
  // is not affected; everything reads zero otherwise.
  always_comb begin
    bus.wbm_adr_o = '0;
    bus.wbm_dat_o = '0;
    bus.wbm_sel_o = '0;
    bus.wbm_we_o  = 1'b0;
    bus.wbm_cyc_o = 1'b0;
    bus.wbm_stb_o = 1'b0;
    bus.wbm_cti_o = 3'b000;
    bus.wbm_bte_o = 2'b00;
    bus.wbs_dat_o = '0;
    if (fwd) begin
      bus.wbm_adr_o = bus.wbs_adr_i[gidx];
      bus.wbm_dat_o = bus.wbs_dat_i[gidx];
      bus.wbm_sel_o = bus.wbs_sel_i[gidx];
      bus.wbm_we_o  = bus.wbs_we_i[gidx];
      bus.wbm_cyc_o = bus.wbs_cyc_i[gidx];
      bus.wbm_stb_o = bus.wbs_stb_i[gidx];
      bus.wbm_cti_o = bus.wbs_cti_i[gidx];
      bus.wbm_bte_o = bus.wbs_bte_i[gidx];
      bus.wbs_dat_o = bus.wbm_dat_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
      assign bus.wbs_ack_o[gi] = fwd & grant_q[gi] & bus.wbm_ack_i;
      assign bus.wbs_rty_o[gi] = fwd & grant_q[gi] & bus.wbm_rty_i;
      assign bus.wbs_err_o[gi] = fwd & grant_q[gi] & (bus.wbm_err_i | wd_fire);
    end
  endgenerate

  assign bus.grant_o   = grant_q;
  assign bus.timeout_o = wd_fire;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wd_cnt_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          ptr_d   = rr_next;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.wbs_cyc_i[gidx]) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end else if (wd_fire) begin
          state_d = S_ABORT;
        end else if ((TIMEOUT > 0) && bus.wbs_stb_i[gidx] && !resp) begin
          wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
      end
      S_ABORT: begin
        // Grant stays held so the aborted master cannot be re-granted early.
        if (!bus.wbs_cyc_i[gidx]) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_msi_wb_arbiter
// Directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mpsoc_msi_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA000_0010;
  localparam logic [31:0] A2 = 32'hA000_0020;
  localparam logic [31:0] A3 = 32'hA000_0030;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpsoc_msi_wb_arbiter_if #(.NUM_MASTERS(N), .DW(DW), .AW(AW)) bus ();

  mpsoc_msi_wb_arbiter #(
    .NUM_MASTERS (N),
    .DW          (DW),
    .AW          (AW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_we_i  = '0;
    bus.wbs_cyc_i = '0;
    bus.wbs_stb_i = '0;
    bus.wbs_cti_i = '0;
    bus.wbs_bte_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst_before;
    logic [3:0] cyc;
    logic       ack, err, rty;
    logic [3:0] g;
    logic       mcyc;
    logic [3:0] ack_o, err_o, rty_o;
    logic [31:0] adr;
  } vec_t;

  function automatic vec_t mk(bit r, logic [3:0] c, logic a, logic e, logic y,
                              logic [3:0] g, logic mc, logic [3:0] ao,
                              logic [3:0] eo, logic [3:0] yo, logic [31:0] adr);
    vec_t v;
    v.rst_before = r; v.cyc = c; v.ack = a; v.err = e; v.rty = y;
    v.g = g; v.mcyc = mc; v.ack_o = ao; v.err_o = eo; v.rty_o = yo; v.adr = adr;
    return v;
  endfunction

  vec_t vecs[$];

  // ---------------- reference model ----------------
  int m_owner, m_ptr, m_wait;
  bit m_dead, m_abort;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_wait = 0; m_dead = 0; m_abort = 0;
  endtask

  task automatic model_check_and_step(input int cyc_no);
    bit          active, fire, rsp;
    int          o;
    logic [3:0]  eg, ea, ee, er, onehot;
    logic [11:0] ectl, actl;
    logic [31:0] eadr, edat, erd;
    o      = m_owner;
    active = (o >= 0) && !m_dead && !m_abort;
    rsp    = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
    fire   = active && bus.wbs_cyc_i[o] && bus.wbs_stb_i[o] && !rsp && (m_wait == TO - 1);
    onehot = (o >= 0) ? 4'(1 << o) : 4'b0;
    eg     = (o >= 0 && !m_dead) ? onehot : 4'b0;
    ea     = (active && bus.wbm_ack_i) ? onehot : 4'b0;
    ee     = (active && (bus.wbm_err_i || fire)) ? onehot : 4'b0;
    er     = (active && bus.wbm_rty_i) ? onehot : 4'b0;
    ectl = '0; eadr = '0; edat = '0; erd = '0;
    if (active) begin
      ectl = {bus.wbs_cyc_i[o], bus.wbs_stb_i[o], bus.wbs_we_i[o], bus.wbs_sel_i[o],
              bus.wbs_cti_i[o], bus.wbs_bte_i[o]};
      eadr = bus.wbs_adr_i[o];
      edat = bus.wbs_dat_i[o];
      erd  = bus.wbm_dat_i;
    end
    actl = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
            bus.wbm_cti_o, bus.wbm_bte_o};
    check($sformatf("rnd%0d_grant", cyc_no), bus.grant_o, eg);
    check($sformatf("rnd%0d_ctl", cyc_no), actl, ectl);
    check($sformatf("rnd%0d_adr_dat", cyc_no), {bus.wbm_adr_o, bus.wbm_dat_o}, {eadr, edat});
    check($sformatf("rnd%0d_rdat", cyc_no), bus.wbs_dat_o, erd);
    check($sformatf("rnd%0d_resp", cyc_no),
          {bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o, bus.timeout_o}, {ea, ee, er, fire});
    // advance the model by one clock
    if (!rst_n) begin
      model_reset();
    end else if (m_dead) begin
      m_dead = 0; m_owner = -1;
    end else if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bus.wbs_cyc_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % N; m_wait = 0;
      end
    end else if (!bus.wbs_cyc_i[o]) begin
      m_dead = 1; m_abort = 0;
    end else if (m_abort) begin
      m_abort = 1;
    end else if (fire) begin
      m_abort = 1; m_wait = 0;
    end else if (bus.wbs_stb_i[o] && !rsp) begin
      m_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
    end else begin
      m_wait = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  int hold[N];
  int deaf;
  int r;

  initial begin
    clear_inputs();

    // Scenario A: single master on port 1, re-request after release
    vecs.push_back(mk(1, 4'b0010, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b0010, 0,0,0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, A1));
    vecs.push_back(mk(0, 4'b0010, 0,0,0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, A1));
    vecs.push_back(mk(0, 4'b0000, 1,0,0, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, A1));
    vecs.push_back(mk(0, 4'b0010, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b0010, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b0010, 0,0,0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000, A1));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, A1));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    // Scenario B: ports 0,2,3 contend; port 0 re-requests at once
    vecs.push_back(mk(1, 4'b1101, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1101, 1,0,0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, A0));
    vecs.push_back(mk(0, 4'b1100, 0,0,0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, A0));
    vecs.push_back(mk(0, 4'b1101, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1101, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1101, 1,0,0, 4'b0100, 1, 4'b0100, 4'b0000, 4'b0000, A2));
    vecs.push_back(mk(0, 4'b1001, 0,0,0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, A2));
    vecs.push_back(mk(0, 4'b1001, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1001, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1001, 1,0,0, 4'b1000, 1, 4'b1000, 4'b0000, 4'b0000, A3));
    vecs.push_back(mk(0, 4'b0001, 0,0,0, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, A3));
    vecs.push_back(mk(0, 4'b0001, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b0001, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b0001, 1,0,0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, A0));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, A0));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    // Scenario C: rty then err to port 3, grant held
    vecs.push_back(mk(1, 4'b1000, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 4'b1000, 0,0,1, 4'b1000, 1, 4'b0000, 4'b0000, 4'b1000, A3));
    vecs.push_back(mk(0, 4'b1000, 0,1,0, 4'b1000, 1, 4'b0000, 4'b1000, 4'b0000, A3));
    vecs.push_back(mk(0, 4'b1000, 1,0,0, 4'b1000, 1, 4'b1000, 4'b0000, 4'b0000, A3));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, A3));
    vecs.push_back(mk(0, 4'b0000, 0,0,0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0));

    do_reset();
    #2;
    check("reset_grant", bus.grant_o, 4'b0);
    check("reset_outs", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_cti_o,
                         bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o, bus.timeout_o}, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      bus.wbs_adr_i = {A3, A2, A1, A0};
      bus.wbs_cyc_i = vecs[i].cyc;
      bus.wbs_stb_i = vecs[i].cyc;
      bus.wbm_ack_i = vecs[i].ack;
      bus.wbm_err_i = vecs[i].err;
      bus.wbm_rty_i = vecs[i].rty;
      #2;
      check($sformatf("vec%0d_grant", i), bus.grant_o, vecs[i].g);
      check($sformatf("vec%0d_cyc_stb", i), {bus.wbm_cyc_o, bus.wbm_stb_o}, {vecs[i].mcyc, vecs[i].mcyc});
      check($sformatf("vec%0d_adr", i), bus.wbm_adr_o, vecs[i].adr);
      check($sformatf("vec%0d_resp", i), {bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o},
            {vecs[i].ack_o, vecs[i].err_o, vecs[i].rty_o});
      tick();
    end

    // Watchdog: port 0 never answered, port 1 waiting
    do_reset();
    bus.wbs_cyc_i = 4'b0011;
    bus.wbs_stb_i = 4'b0011;
    #2;
    check("wd_idle_grant", bus.grant_o, 4'b0);
    tick();
    for (int k = 1; k <= TO; k++) begin
      #2;
      check($sformatf("wd_stb%0d_cyc", k), bus.wbm_cyc_o, 1'b1);
      check($sformatf("wd_stb%0d_timeout", k), bus.timeout_o, (k == TO));
      check($sformatf("wd_stb%0d_err", k), bus.wbs_err_o, (k == TO) ? 4'b0001 : 4'b0000);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #2;
      check($sformatf("wd_abort%0d_cyc", k), bus.wbm_cyc_o, 1'b0);
      check($sformatf("wd_abort%0d_grant", k), bus.grant_o, 4'b0001);
      check($sformatf("wd_abort%0d_resp", k), {bus.wbs_err_o, bus.timeout_o}, 5'b0);
      tick();
    end
    bus.wbs_cyc_i = 4'b0010;
    bus.wbs_stb_i = 4'b0010;
    #2;
    check("wd_drop_cyc", bus.wbm_cyc_o, 1'b0);
    tick();
    #2;
    check("wd_release_grant", {bus.grant_o, bus.wbm_cyc_o}, 5'b0);
    tick();
    #2;
    check("wd_idle2_grant", {bus.grant_o, bus.wbm_cyc_o}, 5'b0);
    tick();
    #2;
    check("wd_next_grant", {bus.grant_o, bus.wbm_cyc_o}, {4'b0010, 1'b1});
    tick();

    // Burst pass-through on port 2; other lanes carry distinct junk
    do_reset();
    bus.wbs_cti_i = {3'b111, 3'b010, 3'b111, 3'b111};
    bus.wbs_bte_i = {2'b11, 2'b00, 2'b11, 2'b11};
    bus.wbs_cyc_i = 4'b0100;
    bus.wbs_stb_i = 4'b0100;
    bus.wbs_adr_i[2] = 32'h200;
    #2;
    check("burst_idle", bus.wbm_cyc_o, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      bus.wbs_adr_i[2] = 32'h200 + 32'(4 * b);
      bus.wbs_cti_i[2] = (b == 3) ? 3'b111 : 3'b010;
      bus.wbm_ack_i    = 1'b1;
      #2;
      check($sformatf("burst%0d_cyc", b), {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
      check($sformatf("burst%0d_adr", b), bus.wbm_adr_o, 32'h200 + 32'(4 * b));
      check($sformatf("burst%0d_cti_bte", b), {bus.wbm_cti_o, bus.wbm_bte_o},
            {((b == 3) ? 3'b111 : 3'b010), 2'b00});
      check($sformatf("burst%0d_ack", b), bus.wbs_ack_o, 4'b0100);
      tick();
    end
    bus.wbs_cyc_i = '0;
    bus.wbs_stb_i = '0;
    bus.wbm_ack_i = 1'b0;
    tick();
    tick();

    // Reset during beat 2 of a port-2 burst, ports 1 and 3 waiting
    do_reset();
    bus.wbs_cyc_i = 4'b0100;
    bus.wbs_stb_i = 4'b0100;
    tick();
    bus.wbs_cyc_i = 4'b1110;
    bus.wbs_stb_i = 4'b1110;
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    #2;
    check("rstb_beat0_grant", bus.grant_o, 4'b0100);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    check("rstb_after_grant", bus.grant_o, 4'b0);
    check("rstb_after_outs", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.wbs_dat_o,
                              bus.wbs_ack_o, bus.timeout_o}, '0);
    tick();
    #2;
    check("rstb_first_grant", bus.grant_o, 4'b0010);
    tick();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    deaf = 0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0 && $urandom_range(0, 5) == 0) hold[i] = $urandom_range(1, 30);
        bus.wbs_cyc_i[i] = (hold[i] > 0);
        bus.wbs_stb_i[i] = (hold[i] > 0) && ($urandom_range(0, 7) != 0);
        if (hold[i] > 0) hold[i]--;
        bus.wbs_adr_i[i] = $urandom;
        bus.wbs_dat_i[i] = $urandom;
        bus.wbs_sel_i[i] = 4'($urandom);
        bus.wbs_we_i[i]  = 1'($urandom);
        bus.wbs_cti_i[i] = 3'($urandom);
        bus.wbs_bte_i[i] = 2'($urandom);
      end
      bus.wbm_dat_i = $urandom;
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      bus.wbm_rty_i = 1'b0;
      if (deaf > 0) begin
        deaf--;
      end else begin
        if ($urandom_range(0, 40) == 0) deaf = $urandom_range(5, 25);
        r = $urandom_range(0, 9);
        bus.wbm_ack_i = (r <= 2);
        bus.wbm_err_i = (r == 3);
        bus.wbm_rty_i = (r == 4);
      end
      #2;
      model_check_and_step(c);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
